// File: rtl/sbdft_pkg.sv
// Shared definitions for the single-bin DFT front end and its wrappers.
// Holds the sequencer state encoding and the DFT length-index width helper.
// Pure declarations; no logic, latency or flow control of its own.
package sbdft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } sbdft_state_e;

  localparam int SBDFT_DFT_LEN_DEF = 128;

  // Width of a length-minus-one index for a DFT of dft_len points.
  function automatic int sbdft_len_w(input int dft_len);
    return (dft_len < 2) ? 1 : $clog2(dft_len);
  endfunction

  localparam int SBDFT_LEN_W_DEF = sbdft_len_w(SBDFT_DFT_LEN_DEF);

endpackage

// File: rtl/sbdft_frame_ctrl_if.sv
// Bundle between the sample/config source and the DFT frame sequencer.
// Wires only; timing is defined by the sequencer.
// No backpressure: samples and config are strobes, the sequencer never stalls them.
interface sbdft_frame_ctrl_if
  import sbdft_pkg::*;
#(
  parameter int DIN_WIDTH       = 16,
  parameter int LEN_W           = SBDFT_LEN_W_DEF,
  parameter int FRAME_CNT_WIDTH = 32
);
  logic                        enable;
  logic                        sync_in;
  logic signed [DIN_WIDTH-1:0] din_re;
  logic signed [DIN_WIDTH-1:0] din_im;
  logic                        din_valid;
  logic [LEN_W-1:0]            cfg_len_m1;
  logic                        cfg_valid;

  logic signed [DIN_WIDTH-1:0] dft_din_re;
  logic signed [DIN_WIDTH-1:0] dft_din_im;
  logic                        dft_din_valid;
  logic                        dft_rst;
  logic [31:0]                 dft_delay_line;
  logic [FRAME_CNT_WIDTH-1:0]  frame_count;
  logic                        sync_err;
  logic                        cfg_err;
  logic [1:0]                  state;

  modport master (
    output enable, sync_in, din_re, din_im, din_valid, cfg_len_m1, cfg_valid,
    input  dft_din_re, dft_din_im, dft_din_valid, dft_rst, dft_delay_line,
           frame_count, sync_err, cfg_err, state
  );

  modport slave (
    input  enable, sync_in, din_re, din_im, din_valid, cfg_len_m1, cfg_valid,
    output dft_din_re, dft_din_im, dft_din_valid, dft_rst, dft_delay_line,
           frame_count, sync_err, cfg_err, state
  );

endinterface

// File: rtl/sbdft_cfg_holder.sv
// Pending DFT-length holder: validates, overwrites and hands a length over at a boundary.
// A fresh legal config is visible combinationally the same cycle; cfg_err is registered (1 cycle).
// No backpressure: a later config overwrites a pending one; take_i clears it.
module sbdft_cfg_holder
  import sbdft_pkg::*;
#(
  parameter int LEN_W = SBDFT_LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid_i,
  input  logic [LEN_W-1:0] cfg_len_m1_i,
  input  logic             take_i,
  output logic             avail_o,
  output logic [LEN_W-1:0] len_o,
  output logic             cfg_err_o
);

  logic             cfg_ok;
  logic             pend_vld_q, pend_vld_d;
  logic [LEN_W-1:0] pend_len_q, pend_len_d;
  logic             cfg_err_q, cfg_err_d;

  // A length of one point is rejected; everything else is legal.
  assign cfg_ok  = cfg_valid_i && (cfg_len_m1_i != '0);
  assign avail_o = cfg_ok || pend_vld_q;
  assign len_o   = cfg_ok ? cfg_len_m1_i : pend_len_q;

  // Pending next state: a take consumes whatever is offered, otherwise a new legal config is stored.
  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_len_d = pend_len_q;
    cfg_err_d  = cfg_valid_i && (cfg_len_m1_i == '0);
    if (take_i) begin
      pend_vld_d = 1'b0;
    end else if (cfg_ok) begin
      pend_vld_d = 1'b1;
      pend_len_d = cfg_len_m1_i;
    end
  end

  // Pending register and error pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_vld_q <= 1'b0;
      pend_len_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_len_q <= pend_len_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign cfg_err_o = cfg_err_q;

endmodule

// File: rtl/sbdft_frame_ctrl.sv
// Frame sequencer for single_bin_dft: aligns to frame sync, gates samples, applies length at frame ends.
// Samples reach the DFT one cycle after input; dft_rst follows the state register.
// No backpressure: samples outside an aligned frame are dropped, not stalled.
module sbdft_frame_ctrl
  import sbdft_pkg::*;
#(
  parameter int DIN_WIDTH       = 16,
  parameter int DFT_LEN         = 128,
  parameter int SETTLE_CYCLES   = 2,
  parameter int FRAME_CNT_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  sbdft_frame_ctrl_if.slave bus
);

  localparam int LEN_W = sbdft_len_w(DFT_LEN);
  localparam int SET_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0] SETTLE_MAX = SET_W'(SETTLE_CYCLES);

  sbdft_state_e                state_q, state_d;
  logic [SET_W-1:0]            settle_q, settle_d;
  logic [LEN_W-1:0]            sample_cnt_q, sample_cnt_d;
  logic [LEN_W-1:0]            delay_line_q, delay_line_d;
  logic [FRAME_CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
  logic                        sync_err_q, sync_err_d;
  logic                        accept;
  logic signed [DIN_WIDTH-1:0] din_re_q, din_im_q;
  logic                        din_vld_q, acc_q;
  logic                        cfg_take, cfg_avail, cfg_err;
  logic [LEN_W-1:0]            cfg_len;

  sbdft_cfg_holder #(.LEN_W(LEN_W)) u_cfg (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid_i  (bus.cfg_valid),
    .cfg_len_m1_i (bus.cfg_len_m1),
    .take_i       (cfg_take),
    .avail_o      (cfg_avail),
    .len_o        (cfg_len),
    .cfg_err_o    (cfg_err)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state, counters and sample qualification; length only changes outside RUN or when leaving it.
  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    sample_cnt_d = sample_cnt_q;
    delay_line_d = delay_line_q;
    frame_cnt_d  = frame_cnt_q;
    sync_err_d   = sync_err_q;
    accept       = 1'b0;
    cfg_take     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        sample_cnt_d = '0;
        if (cfg_avail) begin
          delay_line_d = cfg_len;
          cfg_take     = 1'b1;
        end
        if (bus.enable) begin
          state_d  = ST_ARM;
          settle_d = '0;
        end
      end
      ST_ARM: begin
        sample_cnt_d = '0;
        if (settle_q != SETTLE_MAX) settle_d = settle_q + SET_W'(1);
        if (!bus.enable) state_d = ST_IDLE;
        if (cfg_avail) begin
          // A new length restarts settling so the DFT sees it for the full window.
          delay_line_d = cfg_len;
          cfg_take     = 1'b1;
          settle_d     = '0;
        end else if (bus.enable && settle_q == SETTLE_MAX && bus.sync_in && bus.din_valid) begin
          state_d      = ST_RUN;
          accept       = 1'b1;
          sample_cnt_d = (delay_line_q == '0) ? '0 : LEN_W'(1);
        end
      end
      ST_RUN: begin
        if (bus.din_valid) begin
          if (bus.sync_in && sample_cnt_q != '0) begin
            // Misaligned sync: drop the partial frame and realign.
            sync_err_d   = 1'b1;
            state_d      = ST_ARM;
            settle_d     = '0;
            sample_cnt_d = '0;
          end else begin
            accept = 1'b1;
            if (sample_cnt_q == delay_line_q) begin
              frame_cnt_d  = frame_cnt_q + FRAME_CNT_WIDTH'(1);
              sample_cnt_d = '0;
              if (cfg_avail) begin
                delay_line_d = cfg_len;
                cfg_take     = 1'b1;
                state_d      = ST_ARM;
                settle_d     = '0;
              end else if (!bus.enable) begin
                state_d = ST_IDLE;
              end
            end else begin
              sample_cnt_d = sample_cnt_q + LEN_W'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter, length and error registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      settle_q     <= '0;
      sample_cnt_q <= '0;
      delay_line_q <= LEN_W'(DFT_LEN - 1);
      frame_cnt_q  <= '0;
      sync_err_q   <= 1'b0;
    end else begin
      settle_q     <= settle_d;
      sample_cnt_q <= sample_cnt_d;
      delay_line_q <= delay_line_d;
      frame_cnt_q  <= frame_cnt_d;
      sync_err_q   <= sync_err_d;
    end
  end

  // Sample register: data always captured, strobe qualified by acceptance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      din_re_q  <= '0;
      din_im_q  <= '0;
      din_vld_q <= 1'b0;
      acc_q     <= 1'b0;
    end else begin
      din_re_q  <= bus.din_re;
      din_im_q  <= bus.din_im;
      din_vld_q <= bus.din_valid;
      acc_q     <= accept;
    end
  end

  // State-derived outputs: the DFT is held in reset whenever no frame is running.
  always_comb begin
    bus.dft_rst = (state_q != ST_RUN);
    bus.state   = state_q;
  end

  assign bus.dft_din_re     = din_re_q;
  assign bus.dft_din_im     = din_im_q;
  assign bus.dft_din_valid  = din_vld_q & acc_q;
  assign bus.dft_delay_line = 32'(delay_line_q);
  assign bus.frame_count    = frame_cnt_q;
  assign bus.sync_err       = sync_err_q;
  assign bus.cfg_err        = cfg_err;

endmodule

// File: tb/tb_sbdft_frame_ctrl.sv
// Bench for sbdft_frame_ctrl: scenario tasks with a forwarded-sample scoreboard.
// Expected DFT samples are queued when driven and popped one cycle later.
// Inputs change 1 time unit after the rising edge; outputs are read at the same point.
module tb_sbdft_frame_ctrl;
  import sbdft_pkg::*;

  localparam int DW      = 16;
  localparam int DFT_LEN = 128;
  localparam int LEN_W   = 7;
  localparam int FCW     = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sbdft_frame_ctrl_if #(.DIN_WIDTH(DW), .LEN_W(LEN_W), .FRAME_CNT_WIDTH(FCW)) bus ();

  sbdft_frame_ctrl #(
    .DIN_WIDTH(DW), .DFT_LEN(DFT_LEN), .SETTLE_CYCLES(2), .FRAME_CNT_WIDTH(FCW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [2*DW-1:0] exp_q[$];

  // One clock: drive a sample, queue it if it should reach the DFT, then score the DFT port.
  task automatic cycle(input bit vld, input bit sync, input bit fwd);
    logic [DW-1:0]   re, im;
    logic [2*DW-1:0] exp;
    re = DW'($urandom);
    im = DW'($urandom);
    bus.din_valid = vld;
    bus.sync_in   = sync;
    bus.din_re    = re;
    bus.din_im    = im;
    if (fwd) exp_q.push_back({re, im});
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
    bus.sync_in   = 1'b0;
    n_tests++;
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      if (bus.dft_din_valid !== 1'b1 || {bus.dft_din_re, bus.dft_din_im} !== exp) begin
        n_fail++;
        $display("FAIL dft_sample: got vld=%0b data=%h want vld=1 data=%h",
                 bus.dft_din_valid, {bus.dft_din_re, bus.dft_din_im}, exp);
      end
    end else if (bus.dft_din_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL dft_gate: got dft_din_valid=%0b want 0", bus.dft_din_valid);
    end
  endtask

  task automatic fwd_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    n_tests++; if (bus.state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want 0", bus.state); end
    n_tests++; if (bus.dft_rst !== 1'b1) begin n_fail++; $display("FAIL rst_dft_rst: got %0b want 1", bus.dft_rst); end
    n_tests++; if (bus.dft_delay_line !== 32'd127) begin n_fail++; $display("FAIL rst_len: got %0d want 127", bus.dft_delay_line); end
    n_tests++; if (bus.frame_count !== 32'd0) begin n_fail++; $display("FAIL rst_frames: got %0d want 0", bus.frame_count); end
    n_tests++; if (bus.sync_err !== 1'b0 || bus.cfg_err !== 1'b0) begin n_fail++; $display("FAIL rst_errs: got sync=%0b cfg=%0b want 0 0", bus.sync_err, bus.cfg_err); end
    n_tests++; if (bus.dft_din_re !== '0 || bus.dft_din_im !== '0) begin n_fail++; $display("FAIL rst_data: got %h/%h want 0/0", bus.dft_din_re, bus.dft_din_im); end
    rst = 1'b1;
  endtask

  task automatic test_first_frame();
    bus.enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (i == 0) begin
        n_tests++; if (bus.state !== ST_ARM) begin n_fail++; $display("FAIL arm_entry: got %0d want 1", bus.state); end
      end
    end
    n_tests++; if (bus.dft_rst !== 1'b1) begin n_fail++; $display("FAIL arm_dft_rst: got %0b want 1", bus.dft_rst); end
    cycle(1'b1, 1'b1, 1'b1);
    n_tests++; if (bus.state !== ST_RUN || bus.dft_rst !== 1'b0) begin n_fail++; $display("FAIL sync_take: got state=%0d dft_rst=%0b want 2 0", bus.state, bus.dft_rst); end
    for (int i = 1; i < 128; i++) begin
      cycle(1'b1, 1'b0, 1'b1);
      if (i == 126) begin
        n_tests++; if (bus.frame_count !== 32'd0) begin n_fail++; $display("FAIL frame_early: got %0d want 0", bus.frame_count); end
      end
    end
    n_tests++; if (bus.frame_count !== 32'd1 || bus.state !== ST_RUN) begin n_fail++; $display("FAIL frame_128: got frames=%0d state=%0d want 1 2", bus.frame_count, bus.state); end
  endtask

  task automatic test_sync_err();
    cycle(1'b1, 1'b1, 1'b1);
    n_tests++; if (bus.sync_err !== 1'b0 || bus.state !== ST_RUN) begin n_fail++; $display("FAIL sync_aligned: got err=%0b state=%0d want 0 2", bus.sync_err, bus.state); end
    fwd_n(16);
    cycle(1'b1, 1'b1, 1'b0);
    n_tests++; if (bus.sync_err !== 1'b1) begin n_fail++; $display("FAIL sync_err_set: got %0b want 1", bus.sync_err); end
    n_tests++; if (bus.state !== ST_ARM || bus.dft_rst !== 1'b1) begin n_fail++; $display("FAIL sync_err_arm: got state=%0d dft_rst=%0b want 1 1", bus.state, bus.dft_rst); end
    n_tests++; if (bus.frame_count !== 32'd1) begin n_fail++; $display("FAIL sync_err_frames: got %0d want 1", bus.frame_count); end
    cycle(1'b1, 1'b1, 1'b0);
    n_tests++; if (bus.state !== ST_ARM) begin n_fail++; $display("FAIL settle_early_sync: got %0d want 1", bus.state); end
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    n_tests++; if (bus.state !== ST_RUN) begin n_fail++; $display("FAIL resync: got %0d want 2", bus.state); end
    fwd_n(127);
    n_tests++; if (bus.frame_count !== 32'd2 || bus.sync_err !== 1'b1) begin n_fail++; $display("FAIL resync_frame: got frames=%0d err=%0b want 2 1", bus.frame_count, bus.sync_err); end
  endtask

  task automatic test_cfg_change();
    fwd_n(40);
    bus.cfg_len_m1 = 7'd63;
    bus.cfg_valid  = 1'b1;
    cycle(1'b1, 1'b0, 1'b1);
    n_tests++; if (bus.dft_delay_line !== 32'd127 || bus.state !== ST_RUN) begin n_fail++; $display("FAIL cfg_pending: got len=%0d state=%0d want 127 2", bus.dft_delay_line, bus.state); end
    fwd_n(86);
    n_tests++; if (bus.frame_count !== 32'd2) begin n_fail++; $display("FAIL cfg_mid_frames: got %0d want 2", bus.frame_count); end
    cycle(1'b1, 1'b0, 1'b1);
    n_tests++; if (bus.frame_count !== 32'd3 || bus.dft_delay_line !== 32'd63) begin n_fail++; $display("FAIL cfg_boundary: got frames=%0d len=%0d want 3 63", bus.frame_count, bus.dft_delay_line); end
    n_tests++; if (bus.state !== ST_ARM || bus.dft_rst !== 1'b1) begin n_fail++; $display("FAIL cfg_rearm: got state=%0d dft_rst=%0b want 1 1", bus.state, bus.dft_rst); end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      n_tests++; if (bus.dft_rst !== 1'b1) begin n_fail++; $display("FAIL cfg_rst_window: cycle %0d got %0b want 1", i, bus.dft_rst); end
    end
    cycle(1'b1, 1'b1, 1'b1);
    n_tests++; if (bus.state !== ST_RUN) begin n_fail++; $display("FAIL len64_sync: got %0d want 2", bus.state); end
    fwd_n(62);
    n_tests++; if (bus.frame_count !== 32'd3) begin n_fail++; $display("FAIL len64_early: got %0d want 3", bus.frame_count); end
    cycle(1'b1, 1'b0, 1'b1);
    n_tests++; if (bus.frame_count !== 32'd4 || bus.state !== ST_RUN) begin n_fail++; $display("FAIL len64_frame: got frames=%0d state=%0d want 4 2", bus.frame_count, bus.state); end
    cycle(1'b1, 1'b1, 1'b1);
    fwd_n(62);
    bus.cfg_len_m1 = 7'd127;
    bus.cfg_valid  = 1'b1;
    cycle(1'b1, 1'b0, 1'b1);
    n_tests++; if (bus.frame_count !== 32'd5 || bus.dft_delay_line !== 32'd127 || bus.state !== ST_ARM) begin n_fail++; $display("FAIL cfg_same_cycle: got frames=%0d len=%0d state=%0d want 5 127 1", bus.frame_count, bus.dft_delay_line, bus.state); end
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_enable_drop();
    fwd_n(9);
    bus.enable = 1'b0;
    cycle(1'b1, 1'b0, 1'b1);
    n_tests++; if (bus.state !== ST_RUN || bus.dft_rst !== 1'b0) begin n_fail++; $display("FAIL en_drop_mid: got state=%0d dft_rst=%0b want 2 0", bus.state, bus.dft_rst); end
    fwd_n(116);
    n_tests++; if (bus.state !== ST_RUN || bus.frame_count !== 32'd5) begin n_fail++; $display("FAIL en_drop_run: got state=%0d frames=%0d want 2 5", bus.state, bus.frame_count); end
    cycle(1'b1, 1'b0, 1'b1);
    n_tests++; if (bus.frame_count !== 32'd6 || bus.state !== ST_IDLE || bus.dft_rst !== 1'b1) begin n_fail++; $display("FAIL en_drop_end: got frames=%0d state=%0d dft_rst=%0b want 6 0 1", bus.frame_count, bus.state, bus.dft_rst); end
    cycle(1'b1, 1'b1, 1'b0);
    n_tests++; if (bus.state !== ST_IDLE) begin n_fail++; $display("FAIL idle_hold: got %0d want 0", bus.state); end
  endtask

  task automatic test_cfg_err();
    bus.cfg_len_m1 = 7'd0;
    bus.cfg_valid  = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    n_tests++; if (bus.cfg_err !== 1'b1 || bus.dft_delay_line !== 32'd127) begin n_fail++; $display("FAIL cfg_err_pulse: got err=%0b len=%0d want 1 127", bus.cfg_err, bus.dft_delay_line); end
    cycle(1'b0, 1'b0, 1'b0);
    n_tests++; if (bus.cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_err_clear: got %0b want 0", bus.cfg_err); end
    bus.cfg_len_m1 = 7'd15;
    bus.cfg_valid  = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    n_tests++; if (bus.dft_delay_line !== 32'd15 || bus.cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_idle_load: got len=%0d err=%0b want 15 0", bus.dft_delay_line, bus.cfg_err); end
    bus.enable = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    bus.cfg_len_m1 = 7'd127;
    bus.cfg_valid  = 1'b1;
    cycle(1'b1, 1'b1, 1'b0);
    n_tests++; if (bus.state !== ST_ARM || bus.dft_delay_line !== 32'd127) begin n_fail++; $display("FAIL cfg_arm_load: got state=%0d len=%0d want 1 127", bus.state, bus.dft_delay_line); end
    cycle(1'b1, 1'b1, 1'b0);
    n_tests++; if (bus.state !== ST_ARM) begin n_fail++; $display("FAIL cfg_settle_restart: got %0d want 1", bus.state); end
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    n_tests++; if (bus.state !== ST_RUN) begin n_fail++; $display("FAIL cfg_arm_sync: got %0d want 2", bus.state); end
  endtask

  task automatic test_reset_mid();
    fwd_n(20);
    bus.cfg_len_m1 = 7'd31;
    bus.cfg_valid  = 1'b1;
    cycle(1'b1, 1'b0, 1'b1);
    n_tests++; if (bus.dft_delay_line !== 32'd127) begin n_fail++; $display("FAIL rmid_pending: got %0d want 127", bus.dft_delay_line); end
    rst = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    n_tests++; if (bus.state !== ST_IDLE || bus.dft_rst !== 1'b1) begin n_fail++; $display("FAIL rmid_state: got state=%0d dft_rst=%0b want 0 1", bus.state, bus.dft_rst); end
    n_tests++; if (bus.frame_count !== 32'd0 || bus.sync_err !== 1'b0 || bus.dft_delay_line !== 32'd127) begin n_fail++; $display("FAIL rmid_regs: got frames=%0d err=%0b len=%0d want 0 0 127", bus.frame_count, bus.sync_err, bus.dft_delay_line); end
    bus.enable = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    n_tests++; if (bus.dft_delay_line !== 32'd127) begin n_fail++; $display("FAIL rmid_pending_lost: got %0d want 127", bus.dft_delay_line); end
    bus.enable = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    fwd_n(126);
    n_tests++; if (bus.frame_count !== 32'd0) begin n_fail++; $display("FAIL rmid_early: got %0d want 0", bus.frame_count); end
    cycle(1'b1, 1'b0, 1'b1);
    n_tests++; if (bus.frame_count !== 32'd1 || bus.state !== ST_RUN) begin n_fail++; $display("FAIL rmid_frame: got frames=%0d state=%0d want 1 2", bus.frame_count, bus.state); end
  endtask

  initial begin
    bus.enable     = 1'b0;
    bus.sync_in    = 1'b0;
    bus.din_re     = '0;
    bus.din_im     = '0;
    bus.din_valid  = 1'b0;
    bus.cfg_len_m1 = '0;
    bus.cfg_valid  = 1'b0;
    test_reset();
    test_first_frame();
    test_sync_err();
    test_cfg_change();
    test_enable_drop();
    test_cfg_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sbdft_frame_ctrl.md
Name: sbdft_frame_ctrl

Overview:
Frame sequencer in front of single_bin_dft. It aligns the DFT sample counter to an external frame sync and gates the sample stream into the DFT. DFT-length reconfiguration is applied only at frame boundaries, under a DFT reset window, so no frame is accumulated with mixed lengths. It sits between the ADC/channeliser stream and the DFT, and reports frame counts and alignment faults.

Parameters:
DIN_WIDTH, 16, sample component width (passed through)
DFT_LEN, 128, maximum DFT length; LEN_W = $clog2(DFT_LEN)
SETTLE_CYCLES, 2, minimum cycles in ARM before sync is accepted (covers the DFT's delay_line register)
FRAME_CNT_WIDTH, 32, frame counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
enable  in  1  run request; level
sync_in  in  1  frame-start marker, qualified by din_valid
din_re, din_im  in  DIN_WIDTH each  signed samples
din_valid  in  1  sample strobe
cfg_len_m1  in  LEN_W  requested DFT length minus one
cfg_valid  in  1  config strobe
dft_din_re, dft_din_im  out  DIN_WIDTH each  registered samples to DFT
dft_din_valid  out  1  gated sample strobe to DFT
dft_rst  out  1  active-high reset to DFT
dft_delay_line  out  32  length-minus-one to DFT, zero-extended
frame_count  out  FRAME_CNT_WIDTH  completed frames since reset
sync_err  out  1  sticky: sync seen mid-frame
cfg_err  out  1  one-cycle pulse: illegal config rejected
state  out  2  IDLE=0, ARM=1, RUN=2

Behaviour:
- Reset (rst=0) values: state IDLE, dft_rst=1, dft_delay_line=DFT_LEN-1, dft_din_valid=0, dft_din_re/im=0, frame_count=0, sync_err=0, cfg_err=0, pending config cleared, sample_cnt=0.
- Reset mid-frame: all of the above on the next edge. The partial frame is discarded.
- Datapath: din_re/im are registered once, unconditionally. dft_din_valid equals the registered din_valid ANDed with the registered "sample accepted" qualifier. Latency from din to DFT is 1 cycle.
- IDLE:
  - dft_rst=1.
  - enable=1 -> ARM, settle_cnt cleared.
- ARM:
  - dft_rst=1; settle_cnt increments to SETTLE_CYCLES and saturates.
  - enable=0 -> IDLE.
  - When settle_cnt==SETTLE_CYCLES and sync_in & din_valid: go to RUN and deassert dft_rst in the same cycle.
  - That sample is accepted as sample 0; sample_cnt becomes 1, or 0 if the length is 1 (not legal, see cfg).
- RUN:
  - dft_rst=0. Each din_valid sample is accepted and sample_cnt increments.
  - At the sample where sample_cnt==dft_delay_line (frame end): frame_count++, sample_cnt=0.
  - Then: if a config is pending, load dft_delay_line, clear pending, go to ARM (settle restarts). Else if enable=0, go to IDLE. Else stay in RUN.
  - enable=0 mid-frame has no effect until frame end.
- Sync in RUN:
  - sync_in & din_valid with sample_cnt==0 is aligned; no action.
  - sync_in & din_valid with sample_cnt!=0: set sync_err (sticky until reset), drop that sample (not accepted), go to ARM.
  - frame_count is not incremented for the partial frame.
- Config:
  - cfg_valid with cfg_len_m1==0 -> cfg_err pulse, ignored.
  - In IDLE or ARM, a valid config loads dft_delay_line on the next edge; in ARM settle_cnt restarts.
  - In RUN it is stored as pending. A later cfg_valid overwrites the pending value.
  - cfg_valid in the same cycle as a frame-end sample is applied at that boundary.
- frame_count wraps modulo 2^FRAME_CNT_WIDTH.
- dft_delay_line changes only while dft_rst=1 or in the same cycle dft_rst rises.

Decomposition:
- Shared package sbdft_pkg: state encoding constants (ST_IDLE/ST_ARM/ST_RUN) and LEN_W derivation. The same package is to be used by future single_bin_dft wrappers.
- One sub-module, sbdft_cfg_holder: pending-config register with validity check, overwrite and take-at-boundary handshake.
- FSM, counters and datapath register stay in the top.

Test Plan:
- Reset, enable=1, continuous din_valid, sync at sample 5, cfg default -> dft_rst falls the cycle sync is taken; frame_count=1 after 128 accepted samples; dft_din_valid lags din_valid by 1.
- In RUN with length 128, cfg_len_m1=63 at sample 40 -> frame completes at 128 samples; dft_delay_line=63 and dft_rst=1 for ≥2 cycles; the next sync gives frames of 64.
- sync_in at sample_cnt=17 in RUN -> sync_err=1, that sample is not forwarded, state=ARM, frame_count unchanged.
- cfg_len_m1=0, cfg_valid=1 -> cfg_err pulses 1 cycle; dft_delay_line unchanged.
- enable dropped at sample 10 -> frame runs to 128, frame_count increments, then IDLE with dft_rst=1.
- rst=0 for 1 cycle mid-frame with pending cfg=31 -> dft_delay_line=127, pending lost, state IDLE, frame_count=0.
